// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register file's single write port.
// Round-robin on ties; every grant yields one registered write/ack cycle.
module regfile_write_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] data0_i,
  output logic              ack0_o,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic              ack1_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e              state_q;
  logic                last_q;
  logic                ack0_q;
  logic                ack1_q;
  logic                wr_en_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;

  logic                grant0_d;
  logic                grant1_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;

  // last_q holds the previous winner; a tie goes to the other requester.
  always_comb begin
    grant0_d = req0_i & (~req1_i | last_q);
    grant1_d = req1_i & (~req0_i | ~last_q);
    addr_d   = grant1_d ? addr1_i : addr0_i;
    data_d   = grant1_d ? data1_i : data0_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0_d || grant1_d) begin
            state_q   <= WRITE;
            last_q    <= grant1_d;
            ack0_q    <= grant0_d;
            ack1_q    <= grant1_d;
            // Register 0 is hard-wired zero: acknowledge but suppress the write.
            wr_en_q   <= (addr_d != ADDR_W'(0));
            busy_q    <= 1'b1;
            wr_addr_q <= addr_d;
            wr_data_q <= data_d;
          end
        end
        WRITE: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0_o    = ack0_q;
  assign ack1_o    = ack1_q;
  assign wr_en_o   = wr_en_q;
  assign busy_o    = busy_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule
